mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux between four requesters.
- Grants one requester at a time and drives the mux select.
- Presents the selected data on a valid/ready output channel and bounds each tenure to MAX_HOLD beats.
- Sits between four producer ports and a single downstream consumer.

Parameters:
DATA_W, 8, width of each requester data bus and of out_data.
MAX_HOLD, 4, maximum beats transferred per grant tenure (legal range 1..15).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  per-requester request; requester i holds req[i] high while it has data.
data_in  input  4 x DATA_W  per-requester data, sampled only when granted.
grant  output  4  one-hot grant; all zero when idle.
sel  output  2  mux select, equals the index of the granted requester.
out_valid  output  1  downstream valid.
out_data  output  DATA_W  data_in[sel], combinational through the mux.
out_ready  input  1  downstream ready.

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE, grant=0, sel=0, out_valid=0.
  - Round-robin pointer last=3, so requester 0 has first priority after reset.
  - Beat counter=0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If req!=0, pick the first set req[i] searching last+1, last+2, ... modulo 4.
  - Next cycle: state=BUSY, grant=onehot(i), sel=i, beat counter=0.
  - If req==0, remain IDLE.
- BUSY:
  - out_valid = req[sel] (combinational); out_data = data_in[sel].
  - A beat transfers when out_valid && out_ready; the counter then increments.
- Release from BUSY to IDLE happens when either condition holds at a clock edge:
  - req[sel] is low; or
  - a beat transfers with counter==MAX_HOLD-1.
- On release:
  - grant=0, last=sel.
  - One-cycle arbitration bubble in IDLE before the next grant, so back-to-back tenures are separated by exactly one idle cycle.
- Latency: a request rising in cycle t (arbiter IDLE) gives grant and out_valid in cycle t+1.
- Requests arriving while BUSY wait. A requester may drop req at any time; an unaccepted beat is simply lost.
- Requester holding req continuously with out_ready=1 gets exactly MAX_HOLD beats, then yields to the next requester in order.
- Sole requester is re-granted after the bubble: pattern MAX_HOLD beats, 1 idle, repeat.
- out_ready low stalls the counter; the tenure does not time out while stalled.
- sel holds its last value in IDLE; out_valid is forced 0 in IDLE.
- Reset asserted mid-tenure: all outputs immediately go to reset values; last=3.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- When defined:
  - Adds output grant_cnt, 4 x 16 bits.
  - grant_cnt[i] increments on every IDLE to BUSY transition granting i, saturating at 16'hFFFF.
  - Reset to 0.
- When undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mux_arb_pkg:
  - N_REQ=4, SEL_W=2.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - function rr_pick(req, last), returning the next index.
- Sub-module: reuse the existing single-bit mux4to1 cell, DATA_W instances via generate, driven by sel.
- Hold counter and FSM are written inline.

Test Plan:
- Reset then req=4'b0001, out_ready=1, data_in[0]=8'hA5 held:
  - grant=0001 one cycle later; four beats of A5.
  - Then IDLE one cycle; then re-grant 0001.
- req=4'b1111, out_ready=1 continuous:
  - Grant order 0,1,2,3,0.
  - Each tenure is 4 beats separated by one idle cycle.
- Grant 2 with out_ready=0 for 10 cycles:
  - out_valid=1, counter frozen, grant stays 0100.
  - Then out_ready=1 gives exactly 4 beats.
- Grant 1, drop req[1] after 2 beats with req[3]=1 pending:
  - Release, one IDLE cycle, then grant=1000.
- rst_n low for one cycle mid-tenure (grant=0010):
  - Outputs clear asynchronously.
  - With req=1111 afterwards, first grant=0001.
- With ARB_GRANT_STATS_EN, req=1111 for 3 full rounds:
  - grant_cnt={3,3,3,3}.
  - Reset clears the counts to 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, FSM state type and round-robin pick for mux4_rr_arbiter
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    // Scans downward so the closest requester after last wins.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] last);
        rr_pick = last;
        for (int k = N_REQ; k >= 1; k--)
            if (req[SEL_W'(int'(last) + k)]) rr_pick = SEL_W'(int'(last) + k);
    endfunction
endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// mux4to1: single-bit 4:1 mux cell
module mux4to1 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);
    assign y = d[s];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing a 4:1 data mux over a valid/ready channel
// ARB_GRANT_STATS_EN adds saturating per-requester grant counters (grant_cnt).
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             req,
    input  logic [3:0][DATA_W-1:0] data_in,
    output logic [3:0]             grant,
    output logic [1:0]             sel,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready
`ifdef ARB_GRANT_STATS_EN
    ,
    output logic [3:0][15:0]       grant_cnt
`endif
);
    arb_state_t state;
    logic [SEL_W-1:0] last, pick;
    logic [3:0] cnt;
    logic xfer, rel;
    assign pick = rr_pick(req, last);
    assign out_valid = (state == BUSY) && req[sel];
    assign xfer = out_valid && out_ready;
    assign rel = (state == BUSY) && (!req[sel] || (xfer && cnt == 4'(MAX_HOLD - 1)));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            last  <= 2'd3;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= BUSY;
                sel   <= pick;
                grant <= 4'b0001 << pick;
                cnt   <= '0;
            end
        end else if (rel) begin
            state <= IDLE;
            grant <= '0;
            last  <= sel;
        end else if (xfer) begin
            cnt <= cnt + 4'd1;
        end
`ifdef ARB_GRANT_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) grant_cnt <= '0;
        else if (state == IDLE && |req && grant_cnt[pick] != 16'hFFFF)
            grant_cnt[pick] <= grant_cnt[pick] + 16'd1;
`endif
    for (genvar b = 0; b < DATA_W; b++) begin : g_mux
        mux4to1 u_mux (
            .d({data_in[3][b], data_in[2][b], data_in[1][b], data_in[0][b]}),
            .s(sel),
            .y(out_data[b])
        );
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and randomized checks of mux4_rr_arbiter against a tenure-level model
module tb_mux4_rr_arbiter;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0][DATA_W-1:0] data_in = '0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic out_valid;
    logic [DATA_W-1:0] out_data;
    logic out_ready = 1'b0;
`ifdef ARB_GRANT_STATS_EN
    logic [3:0][15:0] grant_cnt;
`endif
    int checks = 0;
    int errors = 0;
    int m_owner, m_last, m_sel, m_beats;
    int m_cnt [4];
    int xfers;
    logic fix_a5 = 1'b0;
    logic [3:0] prev_g;
    logic [3:0] dut_hist [$];

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .grant(grant), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last = 3;
        m_sel = 0;
        m_beats = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endfunction

    // A tenure ends when the owner drops req or after MAX_HOLD accepted beats.
    function automatic void model_step();
        if (m_owner < 0) begin
            for (int k = 1; k <= 4 && m_owner < 0; k++)
                if (req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
            if (m_owner >= 0) begin
                m_sel = m_owner;
                m_beats = 0;
                if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            end
        end else if (!req[m_owner]) begin
            m_last = m_owner;
            m_owner = -1;
        end else if (out_ready) begin
            m_beats++;
            if (m_beats == MAX_HOLD) begin
                m_last = m_owner;
                m_owner = -1;
            end
        end
    endfunction

    task automatic compare();
        chk("grant", 32'(grant), m_owner < 0 ? 0 : 32'(1 << m_owner));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("out_valid", 32'(out_valid), 32'(m_owner >= 0 && req[m_owner]));
        chk("out_data", 32'(out_data), 32'(data_in[m_sel]));
`ifdef ARB_GRANT_STATS_EN
        for (int i = 0; i < 4; i++) chk("grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif
    endtask

    task automatic tick(input logic [3:0] r, input logic rdy);
        @(negedge clk);
        req = r;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) data_in[i] = (fix_a5 && i == 0) ? 8'hA5 : 8'($urandom);
        #1;
        compare();
        if (out_valid && out_ready) xfers++;
        prev_g = grant;
        @(posedge clk);
        model_step();
        #1;
        if (grant != 0 && prev_g == 0) dut_hist.push_back(grant);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sel", 32'(sel), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        xfers = 0;
        dut_hist.delete();
    endtask

    initial begin
        model_reset();
        do_reset();
        // sole requester: four beats of A5, one idle, re-grant
        fix_a5 = 1'b1;
        tick(4'b0001, 1'b1);
        chk("s1_grant", 32'(grant), 32'h1);
        for (int i = 0; i < MAX_HOLD; i++) tick(4'b0001, 1'b1);
        chk("s1_beats", 32'(xfers), 32'(MAX_HOLD));
        chk("s1_idle", 32'(grant), 0);
        tick(4'b0001, 1'b1);
        chk("s1_regrant", 32'(grant), 32'h1);
        fix_a5 = 1'b0;
        // all requesting: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 21; i++) tick(4'b1111, 1'b1);
        chk("s2_n", 32'(dut_hist.size()), 5);
        for (int i = 0; i < 5 && i < dut_hist.size(); i++)
            chk("s2_order", 32'(dut_hist[i]), 32'(1 << (i % 4)));
        // stall holds the tenure
        do_reset();
        tick(4'b0100, 1'b0);
        for (int i = 0; i < 10; i++) tick(4'b0100, 1'b0);
        chk("s3_hold", 32'(grant), 32'h4);
        chk("s3_nobeat", 32'(xfers), 0);
        for (int i = 0; i < MAX_HOLD; i++) tick(4'b0100, 1'b1);
        chk("s3_beats", 32'(xfers), 32'(MAX_HOLD));
        chk("s3_release", 32'(grant), 0);
        // drop req mid-tenure with 3 pending
        do_reset();
        tick(4'b0010, 1'b1);
        chk("s4_grant", 32'(grant), 32'h2);
        tick(4'b1010, 1'b1);
        tick(4'b1010, 1'b1);
        tick(4'b1000, 1'b1);
        chk("s4_release", 32'(grant), 0);
        tick(4'b1000, 1'b1);
        chk("s4_next", 32'(grant), 32'h8);
        // async reset mid-tenure
        do_reset();
        tick(4'b0010, 1'b1);
        tick(4'b0010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_grant", 32'(grant), 0);
        chk("s5_valid", 32'(out_valid), 0);
        chk("s5_sel", 32'(sel), 0);
        model_reset();
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        tick(4'b1111, 1'b1);
        chk("s5_first", 32'(grant), 32'h1);
`ifdef ARB_GRANT_STATS_EN
        do_reset();
        for (int i = 0; i < 58; i++) tick(4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) chk("s6_cnt", 32'(grant_cnt[i]), 3);
        do_reset();
        for (int i = 0; i < 4; i++) chk("s6_clr", 32'(grant_cnt[i]), 0);
`endif
        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            for (int j = 0; j < 4; j++) r[j] = ($urandom_range(0, 3) != 0);
            tick(r, $urandom_range(0, 3) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
